// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Smallest usable oversampling ratio; smaller requests are raised to this.
    localparam int MIN_PRESCALE = 8;

    // Width of the parity helper argument (widest supported data word).
    localparam int PARITY_FN_W = 9;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Expected parity bit for a data word: even (0) or odd (1) parity.
    // Narrower words are zero-extended, which does not change the XOR.
    function automatic logic uart_parity(input logic [PARITY_FN_W-1:0] data,
                                         input logic                   par_typ);
        return (^data) ^ par_typ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : RX line synchronizer, per-bit edge counter and 3-sample
//               majority vote around the bit centre.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx,
    input  logic                  i_cnt_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_rx_fall,
    output logic                  o_sample_done,
    output logic                  o_bit_wrap,
    output logic                  o_bit_val
);

    logic                  r_sync1;
    logic                  r_rx_s;
    logic                  r_rx_q;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic                  r_smp0;
    logic                  r_smp1;
    logic [PRESCALE_W-1:0] w_half;

    assign w_half = i_prescale >> 1;

    // Two-stage synchronizer plus one delayed copy for edge detection; idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_q  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            r_rx_q  <= r_rx_s;
        end
    end

    // Edge counter: held at 0 while not running so the detection cycle is count 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
        end else if (!i_cnt_en) begin
            r_edge_cnt <= '0;
        end else if (r_edge_cnt == i_prescale - PRESCALE_W'(1)) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        end
    end

    // Capture the first two of the three centre samples; the third is taken live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp0 <= 1'b1;
            r_smp1 <= 1'b1;
        end else begin
            if (r_edge_cnt == w_half - PRESCALE_W'(2)) r_smp0 <= r_rx_s;
            if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_smp1 <= r_rx_s;
        end
    end

    assign o_rx_fall     = r_rx_q & ~r_rx_s;
    assign o_sample_done = (r_edge_cnt == w_half);
    assign o_bit_wrap    = (r_edge_cnt == i_prescale - PRESCALE_W'(1));
    assign o_bit_val     = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver with optional parity,
//               1/2 stop bits, parity/framing error pulses and early return
//               to idle at the final stop bit centre.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_Valid,
    output logic                  PAR_ERR,
    output logic                  FRM_ERR,
    output logic                  BUSY
);

    localparam int                c_BCW       = $clog2(DATA_WIDTH + 4);
    localparam logic [c_BCW-1:0]  c_LAST_DATA = c_BCW'(DATA_WIDTH - 1);

    rx_state_t               r_state;
    logic [c_BCW-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [PRESCALE_W-1:0]   r_presc;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_stop2;
    logic                    r_perr;
    logic                    r_ferr;

    logic                    w_rx_fall;
    logic                    w_sample_done;
    logic                    w_bit_wrap;
    logic                    w_bit_val;
    logic                    w_cnt_en;
    logic                    w_glitch;
    logic                    w_last_stop;
    logic                    w_finish;
    logic                    w_ferr_any;
    logic [PRESCALE_W-1:0]   w_presc_even;
    logic [PRESCALE_W-1:0]   w_presc_eff;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk           (CLK),
        .rst           (RST),
        .i_rx          (RX_IN),
        .i_cnt_en      (w_cnt_en),
        .i_prescale    (r_presc),
        .o_rx_fall     (w_rx_fall),
        .o_sample_done (w_sample_done),
        .o_bit_wrap    (w_bit_wrap),
        .o_bit_val     (w_bit_val)
    );

    // Ratio is forced even and clamped to the minimum before being latched.
    assign w_presc_even = Prescale & ~PRESCALE_W'(1);
    assign w_presc_eff  = (w_presc_even < PRESCALE_W'(MIN_PRESCALE)) ?
                          PRESCALE_W'(MIN_PRESCALE) : w_presc_even;

    assign w_glitch    = (r_state == RX_START) && w_sample_done && w_bit_val;
    assign w_last_stop = (r_bit_cnt == {{(c_BCW-1){1'b0}}, r_stop2});
    assign w_finish    = (r_state == RX_STOP) && w_sample_done && w_last_stop;
    assign w_ferr_any  = r_ferr | ~w_bit_val;

    // Counter runs from the detection cycle and is cleared on the cycle we drop to idle.
    assign w_cnt_en = (r_state == RX_IDLE) ? w_rx_fall : !(w_glitch || w_finish);

    // Receiver FSM, shift register, error accumulation and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= RX_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_presc    <= PRESCALE_W'(MIN_PRESCALE);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            P_DATA     <= '0;
            DATA_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            FRM_ERR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            DATA_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            FRM_ERR    <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_state   <= RX_START;
                        BUSY      <= 1'b1;
                        r_presc   <= w_presc_eff;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_stop2   <= STOP2;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (w_glitch) begin
                        r_state <= RX_IDLE;
                        BUSY    <= 1'b0;
                    end else if (w_bit_wrap) begin
                        r_state   <= RX_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    if (w_sample_done) begin
                        r_shift <= {w_bit_val, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_bit_wrap) begin
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? RX_PARITY : RX_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BCW'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_sample_done) begin
                        r_perr <= (w_bit_val != uart_parity(PARITY_FN_W'(r_shift), r_par_typ));
                    end
                    if (w_bit_wrap) begin
                        r_bit_cnt <= '0;
                        r_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_finish) begin
                        r_state <= RX_IDLE;
                        BUSY    <= 1'b0;
                        PAR_ERR <= r_perr;
                        FRM_ERR <= w_ferr_any;
                        if (!r_perr && !w_ferr_any) begin
                            DATA_Valid <= 1'b1;
                            P_DATA     <= r_shift;
                        end
                    end else begin
                        if (w_sample_done) r_ferr <= w_ferr_any;
                        if (w_bit_wrap)    r_bit_cnt <= r_bit_cnt + c_BCW'(1);
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param: directed scenarios plus
//               randomized frames, with a scoreboard-driven output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic [DW-1:0] P_DATA;
    logic          DATA_Valid;
    logic          PAR_ERR;
    logic          FRM_ERR;
    logic          BUSY;

    uart_rx_param #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .DATA_Valid (DATA_Valid),
        .PAR_ERR    (PAR_ERR),
        .FRM_ERR    (FRM_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int busy_cycles = 0;

    typedef struct {
        bit            valid;
        bit            perr;
        bit            ferr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          pend[$];
    exp_t          sb[$];
    bit            lv[$];
    logic [DW-1:0] last_good;
    exp_t          me;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int eff_p(input int pre);
        int p;
        p = pre - (pre % 2);
        if (p < 8) p = 8;
        return p;
    endfunction

    // Append one frame's pin levels to lv and record its expected outcome.
    task automatic add_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                             input int pre, input bit pflip, input bit st1, input bit st2,
                             input int last_len, input int gap);
        int   p;
        int   start;
        int   ones;
        int   k;
        bit   pbit;
        bit   bits[$];
        exp_t e;
        p     = eff_p(pre);
        start = lv.size();
        ones  = $countones(d);
        pbit  = bit'(((ones + int'(pt)) % 2) != 0) ^ pflip;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(st1);
        if (s2) bits.push_back(st2);
        for (int i = 0; i < bits.size(); i++) begin
            int len;
            len = (i == bits.size() - 1 && last_len > 0) ? last_len : p;
            for (int j = 0; j < len; j++) lv.push_back(bits[i]);
        end
        for (int j = 0; j < gap; j++) lv.push_back(1'b1);
        k       = bits.size() - 1;
        e.perr  = pe && (((ones + int'(pbit)) % 2) != int'(pt));
        e.ferr  = !st1 || (s2 && !st2);
        e.valid = !e.perr && !e.ferr;
        e.data  = e.valid ? d : last_good;
        if (e.valid) last_good = d;
        e.cyc   = start + 3 + k * p + p / 2;
        pend.push_back(e);
    endtask

    // Drive lv onto the pin, one level per clock; optionally disturb config mid-frame.
    task automatic play(input bit scramble);
        int c0;
        @(posedge CLK); #1;
        c0 = cyc;
        foreach (pend[j]) begin
            exp_t e;
            e     = pend[j];
            e.cyc = e.cyc + c0;
            sb.push_back(e);
        end
        pend.delete();
        for (int i = 0; i < lv.size(); i++) begin
            if (i > 0) begin @(posedge CLK); #1; end
            RX_IN = lv[i];
            if (scramble && i == 4) begin
                Prescale = PW'($urandom);
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
                STOP2    = 1'($urandom);
            end
        end
        lv.delete();
    endtask

    task automatic set_cfg(input int pre, input bit pe, input bit pt, input bit s2);
        Prescale = PW'(pre);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p_data"}, 32'(P_DATA), 32'h0);
        check({tag, "_valid"},  32'(DATA_Valid), 32'h0);
        check({tag, "_par_err"}, 32'(PAR_ERR), 32'h0);
        check({tag, "_frm_err"}, 32'(FRM_ERR), 32'h0);
        check({tag, "_busy"},   32'(BUSY), 32'h0);
    endtask

    // Busy-cycle counter used by the glitch and line-held-low scenarios.
    always @(negedge CLK) if (BUSY === 1'b1) busy_cycles <= busy_cycles + 1;

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST === 1'b0 && (DATA_Valid | PAR_ERR | FRM_ERR) === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got valid=%0b perr=%0b ferr=%0b at cycle %0d, expected no pulse",
                         DATA_Valid, PAR_ERR, FRM_ERR, cyc);
            end else begin
                me = sb.pop_front();
                check("valid",         32'(DATA_Valid), 32'(me.valid));
                check("par_err",       32'(PAR_ERR),    32'(me.perr));
                check("frm_err",       32'(FRM_ERR),    32'(me.ferr));
                check("p_data",        32'(P_DATA),     32'(me.data));
                check("pulse_cycle",   32'(cyc),        32'(me.cyc));
                check("busy_at_pulse", 32'(BUSY),       32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RX_IN = 1'b1;
        RST   = 1'b1;
        set_cfg(16, 1'b0, 1'b0, 1'b0);
        last_good = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST = 1'b0;
        repeat (5) @(posedge CLK);

        // 8N1 0xA5, config disturbed after detection.
        set_cfg(16, 1'b0, 1'b0, 1'b0);
        add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 0, 20);
        play(1'b1);
        check("a5_p_data", 32'(P_DATA), 32'hA5);
        check("a5_busy_after", 32'(BUSY), 32'h0);

        // 8E1 0x5A with wrong parity bit.
        set_cfg(16, 1'b1, 1'b0, 1'b0);
        add_frame(8'h5A, 1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b1, 1'b1, 0, 20);
        play(1'b0);

        // Two stop bits, second one low, then line held low.
        set_cfg(16, 1'b0, 1'b0, 1'b1);
        add_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b0, 0, 0);
        play(1'b0);
        busy_cycles = 0;
        repeat (200) @(negedge CLK);
        check("held_low_busy_cycles", 32'(busy_cycles), 32'h0);
        for (int j = 0; j < 20; j++) lv.push_back(1'b1);
        play(1'b0);

        // Start glitch: 4 cycles low.
        set_cfg(16, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++)  lv.push_back(1'b0);
        for (int j = 0; j < 40; j++) lv.push_back(1'b1);
        busy_cycles = 0;
        play(1'b0);
        check("glitch_busy_min", 32'(busy_cycles >= 8),  32'h1);
        check("glitch_busy_max", 32'(busy_cycles <= 16), 32'h1);
        check("glitch_busy_end", 32'(BUSY), 32'h0);

        // 0xFF with a one-cycle spike at the centre of D3, then 0x81 back-to-back.
        begin
            int s;
            s = lv.size();
            add_frame(8'hFF, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 16 / 2 + 3, 0);
            lv[s + 4 * 16 + 16 / 2 - 1] = 1'b0;
            add_frame(8'h81, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 0, 20);
            play(1'b0);
        end

        // Reset in the middle of D4.
        begin
            logic [DW-1:0] d;
            d = 8'h6B;
            for (int j = 0; j < 16; j++) lv.push_back(1'b0);
            for (int b = 0; b < 4; b++)
                for (int j = 0; j < 16; j++) lv.push_back(d[b]);
            for (int j = 0; j < 8; j++) lv.push_back(d[4]);
            play(1'b0);
            check("pre_reset_busy", 32'(BUSY), 32'h1);
            #2 RST = 1'b1;
            #1;
            check_all_zero("midframe_reset");
            RX_IN = 1'b1;
            @(posedge CLK); #1;
            RST = 1'b0;
            last_good = '0;
            repeat (10) @(posedge CLK);
        end
        add_frame(8'h12, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 0, 20);
        play(1'b0);

        // Randomized frames.
        for (int n = 0; n < 25; n++) begin
            logic [DW-1:0] d;
            bit pe, pt, s2, pflip, st1, st2;
            int pre;
            d     = DW'($urandom);
            pe    = 1'($urandom);
            pt    = 1'($urandom);
            s2    = 1'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            st1   = ($urandom_range(0, 7) != 0);
            st2   = ($urandom_range(0, 7) != 0);
            pre   = $urandom_range(0, 40);
            set_cfg(pre, pe, pt, s2);
            add_frame(d, pe, pt, s2, pre, pflip, st1, st2, 0, $urandom_range(2, 30));
            play(1'b1);
        end

        repeat (50) @(posedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
